alu_seq_core: RTL and testbench

Parametrised sequential ALU core, the next generation of the team's 8-bit `main` ALU. It adds a generic data width, registered status flags, a result-valid strobe, illegal-select detection and an optional accumulate mode. Operands are captured into internal registers under a 4-state operand FSM, and one of seven one-hot operations is applied and registered. It sits between the operand/select front end and the display/test harness.

---
 rtl/alu_seq_core.sv | 142 ++++++++++++++
 tb/tb_alu_seq_core.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_core.sv
// Sequential ALU: operands captured under a 4-state FSM, one-hot op result registered 1 edge later.
// Optional ALU_SEQ_ACC_EN: in HOLD, final1 reloads with each new result (accumulate).
module alu_seq_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic [2:0]       in_sel,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [6:0]       out_sel,
  output logic [WIDTH-1:0] final1,
  output logic [WIDTH-1:0] final2,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic             ovf,
  output logic             out_valid,
  output logic             err,
  output logic [1:0]       currState,
  output logic [1:0]       nextState
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    HOLD  = 2'b10,
    CLEAR = 2'b11
  } state_t;

  state_t state, state_nx;

  logic             in_onehot;
  logic             op_onehot;
  logic             active;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;

  assign currState = state;
  assign nextState = state_nx;
  assign in_onehot = $onehot(in_sel);
  assign op_onehot = $onehot(out_sel);
  assign active    = (state == LOAD) || (state == HOLD);

  always_comb begin
    state_nx = state;
    if (!on) begin
      state_nx = IDLE;
    end else begin
      case (in_sel)
        3'b100:  state_nx = HOLD;
        3'b010:  state_nx = LOAD;
        3'b001:  state_nx = CLEAR;
        default: state_nx = state;
      endcase
    end
  end

  // Extended-width add/sub: top bit is carry-out for ADD and borrow for SUB.
  always_comb begin
    sum   = {1'b0, final1} + {1'b0, final2};
    diff  = {1'b0, final1} - {1'b0, final2};
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (out_sel)
      7'b1000000: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (final1[WIDTH-1] == final2[WIDTH-1]) && (res[WIDTH-1] != final1[WIDTH-1]);
      end
      7'b0100000: begin
        res   = diff[WIDTH-1:0];
        res_c = diff[WIDTH];
        res_v = (final1[WIDTH-1] != final2[WIDTH-1]) && (res[WIDTH-1] != final1[WIDTH-1]);
      end
      7'b0010000: res = final1 & final2;
      7'b0001000: res = final1 | final2;
      7'b0000100: res = final1 ^ final2;
      7'b0000010: begin
        res   = {final1[WIDTH-2:0], 1'b0};
        res_c = final1[WIDTH-1];
      end
      7'b0000001: begin
        res   = {1'b0, final1[WIDTH-1:1]};
        res_c = final1[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      final1    <= '0;
      final2    <= '0;
      out       <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_nx;
      err   <= (on && !in_onehot) || (active && !op_onehot);
      // Entering CLEAR wins over both operand load and result update.
      if (state_nx == CLEAR) begin
        final1    <= '0;
        final2    <= '0;
        out       <= '0;
        carry     <= 1'b0;
        zero      <= 1'b0;
        ovf       <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        if (state_nx == LOAD) begin
          final1 <= num1;
          final2 <= num2;
        end
`ifdef ALU_SEQ_ACC_EN
        else if ((state == HOLD) && op_onehot) begin
          final1 <= res;
        end
`endif
        if (active && op_onehot) begin
          out       <= res;
          carry     <= res_c;
          zero      <= (res == '0);
          ovf       <= res_v;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Bench for alu_seq_core: directed vector table, shift/reset sequences, random run vs arithmetic model.
module tb_alu_seq_core;

  logic        clk;
  logic        rst;
  logic        on;
  logic [2:0]  in_sel;
  logic [6:0]  out_sel;
  logic [7:0]  num1, num2;
  logic [15:0] n16a, n16b;

  logic [7:0]  f1, f2, o8;
  logic        c8, z8, v8, vld8, e8;
  logic [1:0]  cs8, ns8;
  logic [15:0] g1, g2, o16;
  logic        c16, z16, v16, vld16, e16;
  logic [1:0]  cs16, ns16;

  int n_chk  = 0;
  int n_fail = 0;

  alu_seq_core #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .on(on), .in_sel(in_sel), .num1(num1), .num2(num2),
    .out_sel(out_sel), .final1(f1), .final2(f2), .out(o8), .carry(c8), .zero(z8),
    .ovf(v8), .out_valid(vld8), .err(e8), .currState(cs8), .nextState(ns8)
  );

  alu_seq_core #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .on(on), .in_sel(in_sel), .num1(n16a), .num2(n16b),
    .out_sel(out_sel), .final1(g1), .final2(g2), .out(o16), .carry(c16), .zero(z16),
    .ovf(v16), .out_valid(vld16), .err(e16), .currState(cs16), .nextState(ns16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state for the 8-bit instance, plain integers.
  int m_state, m_f1, m_f2, m_out, m_c, m_z, m_v, m_vld, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  function automatic int model_ns();
    if (!on) return 0;
    if (in_sel == 3'b100) return 2;
    if (in_sel == 3'b010) return 1;
    if (in_sel == 3'b001) return 3;
    return m_state;
  endfunction

  task automatic model_reset();
    m_state = 0; m_f1 = 0; m_f2 = 0; m_out = 0;
    m_c = 0; m_z = 0; m_v = 0; m_vld = 0; m_err = 0;
  endtask

  task automatic model_edge();
    int a, b, r, c, v, s, ns;
    bit act, opk;
    a = m_f1; b = m_f2; r = 0; c = 0; v = 0;
    act = (m_state == 1) || (m_state == 2);
    opk = $onehot(out_sel);
    case (out_sel)
      7'h40: begin s = a + b; r = s % 256; c = int'(s > 255);
                   s = sx(a) + sx(b); v = int'(s > 127 || s < -128); end
      7'h20: begin r = (a - b + 256) % 256; c = int'(a < b);
                   s = sx(a) - sx(b); v = int'(s > 127 || s < -128); end
      7'h10: r = a & b;
      7'h08: r = a | b;
      7'h04: r = a ^ b;
      7'h02: begin r = (a * 2) % 256; c = a / 128; end
      7'h01: begin r = a / 2; c = a % 2; end
      default: ;
    endcase
    ns = model_ns();
    m_err = int'((on && !$onehot(in_sel)) || (act && !opk));
    if (ns == 3) begin
      m_f1 = 0; m_f2 = 0; m_out = 0; m_c = 0; m_z = 0; m_v = 0; m_vld = 0;
    end else begin
      if (ns == 1) begin
        m_f1 = int'(num1); m_f2 = int'(num2);
      end
`ifdef ALU_SEQ_ACC_EN
      else if (m_state == 2 && opk) m_f1 = r;
`endif
      if (act && opk) begin
        m_out = r; m_c = c; m_z = int'(r == 0); m_v = v; m_vld = 1;
      end else begin
        m_vld = 0;
      end
    end
    m_state = ns;
  endtask

  task automatic cmp_model();
    chk("state", 32'(cs8), 32'(m_state));
    chk("final1", 32'(f1), 32'(m_f1));
    chk("final2", 32'(f2), 32'(m_f2));
    chk("out", 32'(o8), 32'(m_out));
    chk("carry", 32'(c8), 32'(m_c));
    chk("zero", 32'(z8), 32'(m_z));
    chk("ovf", 32'(v8), 32'(m_v));
    chk("out_valid", 32'(vld8), 32'(m_vld));
    chk("err", 32'(e8), 32'(m_err));
  endtask

  // One clock: inputs already driven; check nextState, advance model, sample #1 after edge.
  task automatic step();
    #1;
    chk("nextState", 32'(ns8), 32'(model_ns()));
    model_edge();
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  typedef struct {
    bit         on;
    logic [2:0] isel;
    logic [6:0] osel;
    logic [7:0] n1, n2, eout;
    bit         ec, ez, ev, evld, eerr;
    logic [1:0] est;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(bit o, logic [2:0] is, logic [6:0] os, logic [7:0] a, logic [7:0] b,
                              logic [7:0] eo, bit ec, bit ez, bit ev, bit evl, bit ee, logic [1:0] st);
    vec_t t;
    t.on = o; t.isel = is; t.osel = os; t.n1 = a; t.n2 = b; t.eout = eo;
    t.ec = ec; t.ez = ez; t.ev = ev; t.evld = evl; t.eerr = ee; t.est = st;
    return t;
  endfunction

  localparam logic [2:0] LD = 3'b010, HD = 3'b100, CL = 3'b001;
  localparam logic [6:0] ADD = 7'h40, SUB = 7'h20, SHL = 7'h02, SHR = 7'h01;

  initial begin
    rst = 1'b0; on = 1'b0; in_sel = '0; out_sel = '0;
    num1 = '0; num2 = '0; n16a = '0; n16b = '0;
    model_reset();

    tbl[0]  = mk(1, LD, 7'h00, 8'h57, 8'h1A, 8'h00, 0, 0, 0, 0, 0, 2'd1);
    tbl[1]  = mk(1, HD, ADD,   8'h00, 8'h00, 8'h71, 0, 0, 0, 1, 0, 2'd2);
    tbl[2]  = mk(1, LD, ADD,   8'h1A, 8'h57, 8'h71, 0, 0, 0, 1, 0, 2'd1);
    tbl[3]  = mk(1, HD, SUB,   8'h00, 8'h00, 8'hC3, 1, 0, 0, 1, 0, 2'd2);
    tbl[4]  = mk(1, LD, SUB,   8'h7F, 8'h01, 8'hC3, 1, 0, 0, 1, 0, 2'd1);
    tbl[5]  = mk(1, HD, ADD,   8'h00, 8'h00, 8'h80, 0, 0, 1, 1, 0, 2'd2);
    tbl[6]  = mk(1, LD, ADD,   8'h80, 8'h80, 8'h80, 0, 0, 1, 1, 0, 2'd1);
    tbl[7]  = mk(1, HD, ADD,   8'h00, 8'h00, 8'h00, 1, 1, 1, 1, 0, 2'd2);
    tbl[8]  = mk(1, CL, ADD,   8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 2'd3);
    tbl[9]  = mk(1, 3'b011, 7'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 1, 2'd3);
    tbl[10] = mk(1, CL, 7'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 2'd3);
    tbl[11] = mk(1, LD, 7'h00, 8'h02, 8'h04, 8'h00, 0, 0, 0, 0, 0, 2'd1);
    tbl[12] = mk(1, HD, ADD,   8'h00, 8'h00, 8'h06, 0, 0, 0, 1, 0, 2'd2);
    tbl[13] = mk(1, HD, ADD,   8'h00, 8'h00, 8'h06, 0, 0, 0, 1, 0, 2'd2);
`ifdef ALU_SEQ_ACC_EN
    tbl[14] = mk(1, HD, ADD,   8'h00, 8'h00, 8'h0A, 0, 0, 0, 1, 0, 2'd2);
    tbl[15] = mk(1, HD, ADD,   8'h00, 8'h00, 8'h0E, 0, 0, 0, 1, 0, 2'd2);
    tbl[16] = mk(0, HD, ADD,   8'h00, 8'h00, 8'h12, 0, 0, 0, 1, 0, 2'd0);
    tbl[17] = mk(0, HD, ADD,   8'h00, 8'h00, 8'h12, 0, 0, 0, 0, 0, 2'd0);
`else
    tbl[14] = mk(1, HD, ADD,   8'h00, 8'h00, 8'h06, 0, 0, 0, 1, 0, 2'd2);
    tbl[15] = mk(1, HD, ADD,   8'h00, 8'h00, 8'h06, 0, 0, 0, 1, 0, 2'd2);
    tbl[16] = mk(0, HD, ADD,   8'h00, 8'h00, 8'h06, 0, 0, 0, 1, 0, 2'd0);
    tbl[17] = mk(0, HD, ADD,   8'h00, 8'h00, 8'h06, 0, 0, 0, 0, 0, 2'd0);
`endif

    #12;
    cmp_model();
    chk("rst_out16", 32'(o16), 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      on = tbl[i].on; in_sel = tbl[i].isel; out_sel = tbl[i].osel;
      num1 = tbl[i].n1; num2 = tbl[i].n2;
      step();
      chk($sformatf("vec%0d_out", i), 32'(o8), 32'(tbl[i].eout));
      chk($sformatf("vec%0d_flags", i), {29'd0, c8, z8, v8}, {29'd0, tbl[i].ec, tbl[i].ez, tbl[i].ev});
      chk($sformatf("vec%0d_vld", i), 32'(vld8), 32'(tbl[i].evld));
      chk($sformatf("vec%0d_err", i), 32'(e8), 32'(tbl[i].eerr));
      chk($sformatf("vec%0d_state", i), 32'(cs8), 32'(tbl[i].est));
    end

    // 16-bit shifts: both shifts read 0x8001.
    on = 1'b1; in_sel = LD; out_sel = '0; n16a = 16'h8001; n16b = 16'h1234;
    step();
    in_sel = HD; out_sel = SHL;
    step();
    chk("shl16_out", 32'(o16), 32'h0002);
    chk("shl16_carry", 32'(c16), 32'h1);
    chk("shl16_zero", 32'(z16), 32'h0);
    out_sel = SHR;
    step();
    chk("shr16_out", 32'(o16), 32'h4000);
    chk("shr16_carry", 32'(c16), 32'h1);
    chk("shr16_vld", 32'(vld16), 32'h1);

    // Asynchronous reset between edges while in HOLD.
    in_sel = LD; out_sel = '0; num1 = 8'h33; num2 = 8'h44;
    step();
    in_sel = HD; out_sel = ADD;
    step();
    chk("pre_rst_out", 32'(o8), 32'h77);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    cmp_model();
    chk("arst_out16", 32'(o16), 32'h0);
    chk("arst_state16", 32'(cs16), 32'h0);
    @(posedge clk);
    #1;
    cmp_model();
    on = 1'b0;
    #2;
    rst = 1'b1;
    step();
    chk("post_rst_state", 32'(cs8), 32'h0);
    chk("post_rst_vld", 32'(vld8), 32'h0);

    // Random run against the model.
    for (int i = 0; i < 400; i++) begin
      on = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 4))
        0: in_sel = 3'($urandom_range(0, 7));
        1: in_sel = CL;
        2: in_sel = LD;
        default: in_sel = HD;
      endcase
      if ($urandom_range(0, 7) == 0) out_sel = 7'($urandom_range(0, 127));
      else out_sel = 7'(1 << $urandom_range(0, 6));
      num1 = 8'($urandom_range(0, 255));
      num2 = 8'($urandom_range(0, 255));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
